// File: rtl/sumador_serie_ctrl.sv
// sumador_serie_ctrl: wide adder sequencer driving one external 4-bit adder, one nibble per clock
// Optional macro SUMADOR_SUB_EN adds the resta port for two's-complement subtraction.
module sumador_serie_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   cin,
`ifdef SUMADOR_SUB_EN
   input  logic                   resta,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic [3:0]             s4_a,
   output logic [3:0]             s4_b,
   output logic                   s4_cin,
   input  logic [3:0]             s4_sum,
   input  logic                   s4_cout
);
   localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t               st;
   logic [IW-1:0]        idx;
   logic [4*NIBBLES-1:0] a_r, b_r, b_in;
   logic                 c_r, c_in;

`ifdef SUMADOR_SUB_EN
   assign b_in = resta ? ~op_b : op_b;
   assign c_in = resta | cin;
`else
   assign b_in = op_b;
   assign c_in = cin;
`endif

   assign s4_a   = st == RUN ? a_r[4*idx+:4] : 4'd0;
   assign s4_b   = st == RUN ? b_r[4*idx+:4] : 4'd0;
   assign s4_cin = st == RUN ? c_r : 1'b0;

   // Sequencer: accept in IDLE/FIN, one nibble per edge in RUN, done pulse in FIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= IDLE;
         idx  <= '0;
         a_r  <= '0;
         b_r  <= '0;
         c_r  <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         case (st)
            IDLE, FIN: begin
               done <= 1'b0;
               if (start) begin
                  a_r  <= op_a;
                  b_r  <= b_in;
                  c_r  <= c_in;
                  idx  <= '0;
                  sum  <= '0;
                  busy <= 1'b1;
                  st   <= RUN;
               end else begin
                  st <= IDLE;
               end
            end
            RUN: begin
               sum[4*idx+:4] <= s4_sum;
               c_r           <= s4_cout;
               idx           <= idx + 1'b1;
               if (idx == LAST) begin
                  cout <= s4_cout;
                  busy <= 1'b0;
                  done <= 1'b1;
                  st   <= FIN;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// tb_sumador_serie_ctrl: directed self-checking bench with a behavioural 4-bit adder
module tb_sumador_serie_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, r = 1'b0;
   logic [15:0] op_a = '0, op_b = '0, sum;
   logic        busy, done, cout, s4_cin, s4_cout;
   logic [3:0]  s4_a, s4_b, s4_sum;
   int          n_chk = 0, n_fail = 0;

   sumador_serie_ctrl #(.NIBBLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SUMADOR_SUB_EN
      .resta(r),
`endif
      .busy(busy), .done(done), .sum(sum), .cout(cout),
      .s4_a(s4_a), .s4_b(s4_b), .s4_cin(s4_cin), .s4_sum(s4_sum), .s4_cout(s4_cout)
   );

   assign {s4_cout, s4_sum} = 5'(s4_a) + 5'(s4_b) + 5'(s4_cin);

   always #5 clk = ~clk;

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, input logic rs);
      op_a = a; op_b = b; cin = c; r = rs; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 1;
      while (!done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({busy, done, cout, sum, s4_a, s4_b, s4_cin} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset: outputs %h, required 0", {busy, done, cout, sum, s4_a, s4_b, s4_cin});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int cnt;
      issue(16'h0001, 16'h0001, 1'b0, 1'b0);
      n_chk++;
      if ({busy, s4_a, s4_b, s4_cin} !== {1'b1, 4'h1, 4'h1, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_nib0: busy/a/b/cin %b/%h/%h/%b, required 1/1/1/0", busy, s4_a, s4_b, s4_cin);
      end
      wait_done(cnt);
      n_chk++;
      if (cnt !== 5) begin
         n_fail++;
         $display("FAIL basic_latency: %0d, required 5", cnt);
      end
      n_chk++;
      if ({busy, sum, cout} !== {1'b0, 16'h0002, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_result: busy=%b sum=%h cout=%b, required 0/0002/0", busy, sum, cout);
      end
      @(negedge clk);
      n_chk++;
      if ({done, busy, sum} !== {2'b00, 16'h0002}) begin
         n_fail++;
         $display("FAIL basic_after: done=%b busy=%b sum=%h, required 0/0/0002", done, busy, sum);
      end
   endtask

   task automatic test_ripple;
      int cnt;
      logic [3:0] cs;
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      n_chk++;
      if (sum !== 16'h0000) begin
         n_fail++;
         $display("FAIL ripple_clear: sum=%h, required 0000", sum);
      end
      cs[0] = s4_cin;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         cs[k] = s4_cin;
      end
      n_chk++;
      if (cs !== 4'b1110) begin
         n_fail++;
         $display("FAIL ripple_cin: nibble carries %b, required 1110", cs);
      end
      wait_done(cnt);
      n_chk++;
      if ({sum, cout} !== {16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL ripple_result: sum=%h cout=%b, required 0000/1", sum, cout);
      end
   endtask

   task automatic test_back_to_back;
      int cnt;
      @(negedge clk);
      issue(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait_done(cnt);
      n_chk++;
      if ({sum, cout} !== {16'h5556, 1'b0}) begin
         n_fail++;
         $display("FAIL cin_result: sum=%h cout=%b, required 5556/0", sum, cout);
      end
      issue(16'h0008, 16'h0007, 1'b0, 1'b0);
      n_chk++;
      if ({busy, done} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_accept: busy/done %b, required 10", {busy, done});
      end
      wait_done(cnt);
      n_chk++;
      if (cnt !== 5) begin
         n_fail++;
         $display("FAIL b2b_latency: %0d, required 5", cnt);
      end
      n_chk++;
      if ({sum, cout} !== {16'h000F, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_result: sum=%h cout=%b, required 000F/0", sum, cout);
      end
   endtask

   task automatic test_start_in_run;
      int nd = 0, lat = 0;
      logic [15:0] res = '0;
      logic co = 1'b0;
      @(negedge clk);
      issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      for (int i = 2; i <= 12; i++) begin
         if (i == 3) begin
            op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1; start = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            nd++;
            lat = i;
            res = sum;
            co  = cout;
         end
      end
      n_chk++;
      if (nd !== 1 || lat !== 5) begin
         n_fail++;
         $display("FAIL run_start_done: count=%0d at=%0d, required 1 at 5", nd, lat);
      end
      n_chk++;
      if ({res, co} !== {16'h1010, 1'b0}) begin
         n_fail++;
         $display("FAIL run_start_result: sum=%h cout=%b, required 1010/0", res, co);
      end
   endtask

   task automatic test_reset_mid;
      int cnt, nd = 0;
      issue(16'h2222, 16'h3333, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, done, cout, sum, s4_a, s4_b, s4_cin} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_mid: outputs %h, required 0", {busy, done, cout, sum, s4_a, s4_b, s4_cin});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done) nd++;
      end
      n_chk++;
      if (nd !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_done: %0d pulses, required 0", nd);
      end
      issue(16'h0005, 16'h0009, 1'b0, 1'b0);
      wait_done(cnt);
      n_chk++;
      if ({sum, cout} !== {16'h000E, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_next: sum=%h cout=%b, required 000E/0", sum, cout);
      end
   endtask

`ifdef SUMADOR_SUB_EN
   task automatic test_sub;
      int cnt;
      @(negedge clk);
      issue(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_done(cnt);
      n_chk++;
      if ({sum, cout} !== {16'hFFFE, 1'b0}) begin
         n_fail++;
         $display("FAIL sub_borrow: sum=%h cout=%b, required FFFE/0", sum, cout);
      end
      issue(16'h0007, 16'h0004, 1'b0, 1'b1);
      wait_done(cnt);
      n_chk++;
      if ({sum, cout} !== {16'h0003, 1'b1}) begin
         n_fail++;
         $display("FAIL sub_noborrow: sum=%h cout=%b, required 0003/1", sum, cout);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_ripple;
      test_back_to_back;
      test_start_in_run;
      test_reset_mid;
`ifdef SUMADOR_SUB_EN
      test_sub;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
